burst_rr_arbiter: RTL and testbench
===================================

BURST_RR_ARBITER -- requirements
Module: burst_rr_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 5, giving the number of source FIFOs.
REQ-002 SHALL have parameter DSIZE, default 32, giving the data word width.
REQ-003 SHALL have parameter BW, default 8, giving the BURST_MAX width.
REQ-004 SHALL have port CLK, in, 1, the single clock for all logic.
REQ-005 SHALL have port RST, in, 1, asynchronous active-high reset.
REQ-006 SHALL have port SRC_EMPTY, in, WIDTH: per-source first-word-fall-through FIFO empty flag.
REQ-007 SHALL have port SRC_DATA, in, WIDTH*DSIZE: source i word on bits [i*DSIZE +: DSIZE], valid while !SRC_EMPTY[i].
REQ-008 SHALL have port SRC_READ, out, WIDTH: per-source pop strobe, consumed on the same CLK edge.
REQ-009 SHALL have port SRC_ENABLE, in, WIDTH: per-source arbitration enable mask.
REQ-010 SHALL have port BURST_MAX, in, BW: maximum words per grant; 0 means unlimited.
REQ-011 SHALL have port OUT_READY, in, 1: sink can accept at least one more word after the current cycle.
REQ-012 SHALL have port OUT_WRITE, out, 1: registered sink write strobe.
REQ-013 SHALL have port OUT_DATA, out, DSIZE: registered sink data, valid when OUT_WRITE=1.
REQ-014 SHALL have port GRANT_ID, out, $clog2(WIDTH): index of the currently or last granted source.
REQ-015 SHALL have port BUSY, out, 1: high while in GRANT.

Function
REQ-016 SHALL implement a two-state FSM, IDLE and GRANT.
REQ-017 In IDLE, SHALL scan the requests (SRC_ENABLE & ~SRC_EMPTY) round-robin, starting at PTR and wrapping from WIDTH-1 to 0; on a hit it SHALL load GRANT_ID, clear the burst counter and enter GRANT on the next edge.
REQ-018 IDLE SHALL last exactly one cycle when any request exists, and SHALL hold when none exists.
REQ-019 In GRANT, SRC_READ[GRANT_ID] SHALL be combinational: BUSY & OUT_READY & ~SRC_EMPTY[g] & SRC_ENABLE[g] & ~quota_hit. All other SRC_READ bits SHALL be 0.
REQ-020 On each pop, SHALL register OUT_WRITE=1 and OUT_DATA equal to the popped word on the same edge (latency 1). Otherwise OUT_WRITE SHALL be 0 and OUT_DATA SHALL hold its value.
REQ-021 The burst counter SHALL increment per pop and saturate at all ones. quota_hit SHALL be (BURST_MAX!=0) & (cnt==BURST_MAX).
REQ-022 GRANT SHALL exit to IDLE on the edge after any of: SRC_EMPTY[g]=1, SRC_ENABLE[g]=0, or quota_hit=1. On exit, PTR SHALL become GRANT_ID+1 mod WIDTH.
REQ-023 OUT_READY=0 in GRANT SHALL stall without exiting and without counting.
REQ-024 A pop on the last word (EMPTY rising in the next cycle) SHALL be forwarded before exit; no word SHALL be lost or duplicated.
REQ-025 BURST_MAX changes SHALL take effect combinationally. A new value at or below the current count SHALL cause exit at once.

Reset
REQ-026 RST SHALL force state=IDLE, PTR=0, GRANT_ID=0, cnt=0, OUT_WRITE=0, OUT_DATA=0 and BUSY=0 asynchronously. SRC_READ SHALL be 0 during reset.
REQ-027 Reset mid-burst SHALL abandon the burst. The first grant after release SHALL go to the lowest requesting index.

Configuration
REQ-028 With macro BURST_RR_ARBITER_STATS_EN defined, SHALL add output STALL_CNT, 16 bits. It SHALL count cycles with BUSY & ~SRC_EMPTY[g] & ~OUT_READY, saturate at 16'hFFFF, and clear on RST. Without the macro, the port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-029 WIDTH=5, BURST_MAX=0, source 2 holds 10 words, others empty -> 10 consecutive OUT_WRITE pulses with data in order, then BUSY falls and GRANT_ID=2.
REQ-030 Sources 0,1,4 each hold 8 words, BURST_MAX=3 -> grant order 0,1,4,0,1,4,0,1,4 with bursts 3,3,3,3,3,3,2,2,2 and one idle cycle between bursts.
REQ-031 OUT_READY toggled 1-0-1 every cycle during a 6-word burst -> exactly 6 OUT_WRITE pulses, no loss or duplication, with the stalls counted in STALL_CNT when BURST_RR_ARBITER_STATS_EN is defined.
REQ-032 SRC_ENABLE[1] cleared after the 2nd pop of a source-1 burst -> no 3rd pop; the next grant goes to a source above 1 in round-robin order.
REQ-033 RST asserted mid-burst of source 3 -> OUT_WRITE=0 and SRC_READ=0 immediately; after release, with sources 1 and 3 requesting, the first grant is 1.

Source files
------------

// File: rtl/burst_rr_arbiter.sv
// Round-robin burst arbiter: drains first-word-fall-through source FIFOs into a single sink,
// one grant at a time, each grant capped at BURST_MAX words. Define BURST_RR_ARBITER_STATS_EN for STALL_CNT.
module burst_rr_arbiter #(
    parameter int WIDTH = 5,
    parameter int DSIZE = 32,
    parameter int BW    = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [WIDTH-1:0]         SRC_EMPTY,
    input  logic [WIDTH*DSIZE-1:0]   SRC_DATA,
    output logic [WIDTH-1:0]         SRC_READ,
    input  logic [WIDTH-1:0]         SRC_ENABLE,
    input  logic [BW-1:0]            BURST_MAX,
    input  logic                     OUT_READY,
    output logic                     OUT_WRITE,
    output logic [DSIZE-1:0]         OUT_DATA,
    output logic [$clog2(WIDTH)-1:0] GRANT_ID,
    output logic                     BUSY
`ifdef BURST_RR_ARBITER_STATS_EN
    ,
    output logic [15:0]              STALL_CNT
`endif
);

    localparam int GW = $clog2(WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [BW-1:0]     cnt_q, cnt_d;
    logic              out_write_q, out_write_d;
    logic [DSIZE-1:0]  out_data_q, out_data_d;

    logic [WIDTH-1:0]  req_s;
    logic              hit_s;
    logic [GW-1:0]     hit_idx_s;
    int                cand_s;
    logic              cur_empty_s;
    logic              cur_enable_s;
    logic              quota_hit_s;
    logic              pop_s;
    logic              exit_s;

    assign req_s        = SRC_ENABLE & ~SRC_EMPTY;
    assign cur_empty_s  = SRC_EMPTY[grant_q];
    assign cur_enable_s = SRC_ENABLE[grant_q];
    // ">=" rather than "==" so a BURST_MAX lowered below the running count ends the burst at once.
    assign quota_hit_s  = (BURST_MAX != {BW{1'b0}}) && (cnt_q >= BURST_MAX);
    assign pop_s        = (state_q == ST_GRANT) && OUT_READY && !cur_empty_s
                          && cur_enable_s && !quota_hit_s;
    assign exit_s       = cur_empty_s || !cur_enable_s || quota_hit_s;

    // Round-robin search for the first requesting source at or after ptr_q.
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = {GW{1'b0}};
        cand_s    = 0;
        for (int i = 0; i < WIDTH; i++) begin
            cand_s = int'(ptr_q) + i;
            if (cand_s >= WIDTH) begin
                cand_s = cand_s - WIDTH;
            end else begin
                cand_s = cand_s;
            end
            if (!hit_s && req_s[cand_s]) begin
                hit_s     = 1'b1;
                hit_idx_s = cand_s[GW-1:0];
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    // Pop strobe back to the granted FIFO.
    always_comb begin
        SRC_READ = {WIDTH{1'b0}};
        if (pop_s) begin
            SRC_READ[grant_q] = 1'b1;
        end else begin
            SRC_READ = {WIDTH{1'b0}};
        end
    end

    // Next-state logic for the IDLE/GRANT controller and the output pipeline.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        out_write_d = 1'b0;
        out_data_d  = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (hit_s) begin
                    state_d = ST_GRANT;
                    grant_d = hit_idx_s;
                    cnt_d   = {BW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (pop_s) begin
                    out_write_d = 1'b1;
                    out_data_d  = SRC_DATA[int'(grant_q)*DSIZE +: DSIZE];
                    if (cnt_q != {BW{1'b1}}) begin
                        cnt_d = cnt_q + {{(BW-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    out_write_d = 1'b0;
                end
                // Pop and exit are mutually exclusive: every exit cause also blocks the pop.
                if (exit_s) begin
                    state_d = ST_IDLE;
                    if (grant_q == GW'(WIDTH-1)) begin
                        ptr_d = {GW{1'b0}};
                    end else begin
                        ptr_d = grant_q + {{(GW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller and output registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            ptr_q       <= {GW{1'b0}};
            grant_q     <= {GW{1'b0}};
            cnt_q       <= {BW{1'b0}};
            out_write_q <= 1'b0;
            out_data_q  <= {DSIZE{1'b0}};
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            out_write_q <= out_write_d;
            out_data_q  <= out_data_d;
        end
    end

    assign OUT_WRITE = out_write_q;
    assign OUT_DATA  = out_data_q;
    assign GRANT_ID  = grant_q;
    assign BUSY      = (state_q == ST_GRANT);

`ifdef BURST_RR_ARBITER_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Counts granted cycles where data is waiting but the sink is full.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (BUSY && !cur_empty_s && !OUT_READY && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
`endif

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Self-checking bench for burst_rr_arbiter: queue-modelled FWFT sources, output scoreboard,
// a first-grant vector table and hand sequences for bursts, stalls, disable and reset.
module tb_burst_rr_arbiter;

    localparam int W   = 5;
    localparam int DS  = 32;
    localparam int BWP = 8;

    logic            CLK;
    logic            RST;
    logic [W-1:0]    SRC_EMPTY;
    logic [W*DS-1:0] SRC_DATA;
    logic [W-1:0]    SRC_READ;
    logic [W-1:0]    SRC_ENABLE;
    logic [BWP-1:0]  BURST_MAX;
    logic            OUT_READY;
    logic            OUT_WRITE;
    logic [DS-1:0]   OUT_DATA;
    logic [2:0]      GRANT_ID;
    logic            BUSY;
`ifdef BURST_RR_ARBITER_STATS_EN
    logic [15:0]     STALL_CNT;
`endif

    burst_rr_arbiter #(.WIDTH(W), .DSIZE(DS), .BW(BWP)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .SRC_EMPTY  (SRC_EMPTY),
        .SRC_DATA   (SRC_DATA),
        .SRC_READ   (SRC_READ),
        .SRC_ENABLE (SRC_ENABLE),
        .BURST_MAX  (BURST_MAX),
        .OUT_READY  (OUT_READY),
        .OUT_WRITE  (OUT_WRITE),
        .OUT_DATA   (OUT_DATA),
        .GRANT_ID   (GRANT_ID),
        .BUSY       (BUSY)
`ifdef BURST_RR_ARBITER_STATS_EN
        ,
        .STALL_CNT  (STALL_CNT)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [31:0] fifo [W][$];
    logic [31:0] exp_q [$];
    int          ser [W];
    int          pops [W];
    int          total = 0;
    int          bad   = 0;
    int          nwr   = 0;

    typedef struct {
        logic [4:0] en;
        logic [4:0] ld;
        logic       busy;
        logic [2:0] gid;
        logic [4:0] rd;
    } vec_t;
    vec_t tbl [7];

    function automatic logic [31:0] mk(input int s, input int k);
        return {s[7:0], 8'h5A, k[15:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < W; i++) begin
            if (fifo[i].size() == 0) begin
                SRC_EMPTY[i] = 1'b1;
                SRC_DATA[i*DS +: DS] = 32'h0;
            end else begin
                SRC_EMPTY[i] = 1'b0;
                SRC_DATA[i*DS +: DS] = fifo[i][0];
            end
        end
    endtask

    task automatic load(input int s, input int n);
        for (int k = 0; k < n; k++) begin
            fifo[s].push_back(mk(s, ser[s]));
            ser[s]++;
        end
        refresh();
    endtask

    task automatic monitor();
        logic [31:0] e;
        if (OUT_WRITE) begin
            nwr++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got %0h expected no write", OUT_DATA);
            end else begin
                e = exp_q.pop_front();
                check("out_data", OUT_DATA, e);
                check("write_grant_id", {29'd0, GRANT_ID}, {24'd0, e[31:24]});
            end
        end
    endtask

    // One clock: sample the pop strobe before the edge, consume the popped words after it.
    task automatic tick();
        logic [W-1:0] rd;
        @(negedge CLK);
        rd = SRC_READ;
        @(posedge CLK);
        #1;
        for (int i = 0; i < W; i++) begin
            if (rd[i] && fifo[i].size() > 0) begin
                void'(fifo[i].pop_front());
                pops[i]++;
            end
        end
        refresh();
        monitor();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        for (int i = 0; i < W; i++) begin
            fifo[i].delete();
            ser[i]  = 0;
            pops[i] = 0;
        end
        exp_q.delete();
        SRC_ENABLE = 5'b11111;
        BURST_MAX  = 8'd0;
        OUT_READY  = 1'b1;
        refresh();
        tick();
        RST = 1'b0;
    endtask

    // Reference arbitration over a copy of the source queues.
    task automatic model_rr(input int ptr0, input int bm);
        logic [31:0] qc [W][$];
        int ptr;
        int g;
        int n;
        ptr = ptr0;
        for (int i = 0; i < W; i++) qc[i] = fifo[i];
        for (int guard = 0; guard < 100; guard++) begin
            g = -1;
            for (int j = 0; j < W; j++) begin
                if (g < 0 && SRC_ENABLE[(ptr + j) % W] && qc[(ptr + j) % W].size() > 0)
                    g = (ptr + j) % W;
            end
            if (g < 0) break;
            n = 0;
            while (qc[g].size() > 0 && (bm == 0 || n < bm)) begin
                exp_q.push_back(qc[g].pop_front());
                n++;
            end
            ptr = (g + 1) % W;
        end
    endtask

    task automatic drain(input string nm, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check(nm, exp_q.size(), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        int first_w, last_w, w0, n, idle, kk [W];
        bit started, dis, ld0;
`ifdef BURST_RR_ARBITER_STATS_EN
        int stall_exp;
`endif
        tbl[0] = '{5'b11111, 5'b00000, 1'b0, 3'd0, 5'b00000};
        tbl[1] = '{5'b11111, 5'b00100, 1'b1, 3'd2, 5'b00100};
        tbl[2] = '{5'b11111, 5'b10010, 1'b1, 3'd1, 5'b00010};
        tbl[3] = '{5'b11101, 5'b00011, 1'b1, 3'd0, 5'b00001};
        tbl[4] = '{5'b11100, 5'b00011, 1'b0, 3'd0, 5'b00000};
        tbl[5] = '{5'b10000, 5'b11111, 1'b1, 3'd4, 5'b10000};
        tbl[6] = '{5'b11111, 5'b11000, 1'b1, 3'd3, 5'b01000};

        RST = 1'b1;
        SRC_ENABLE = 5'b11111;
        BURST_MAX  = 8'd0;
        OUT_READY  = 1'b1;
        refresh();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_out_write", {31'd0, OUT_WRITE}, 32'd0);
        check("rst_out_data", OUT_DATA, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_grant_id", {29'd0, GRANT_ID}, 32'd0);
        check("rst_src_read", {27'd0, SRC_READ}, 32'd0);

        // First grant after reset goes to the lowest requesting, enabled source.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            SRC_ENABLE = tbl[v].en;
            for (int s = 0; s < W; s++) if (tbl[v].ld[s]) load(s, 2);
            tick();
            check("tbl_busy", {31'd0, BUSY}, {31'd0, tbl[v].busy});
            check("tbl_grant_id", {29'd0, GRANT_ID}, {29'd0, tbl[v].gid});
            check("tbl_src_read", {27'd0, SRC_READ}, {27'd0, tbl[v].rd});
        end

        // Unlimited burst of 10 words from source 2.
        do_reset();
        load(2, 10);
        model_rr(0, 0);
        w0 = nwr; first_w = -1; last_w = -1; n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            tick();
            if (OUT_WRITE) begin
                if (first_w < 0) first_w = n;
                last_w = n;
            end
            n++;
        end
        check("s10_drain", exp_q.size(), 32'd0);
        check("s10_consecutive", last_w - first_w, 32'd9);
        check("s10_count", nwr - w0, 32'd10);
        tick();
        check("s10_busy_fall", {31'd0, BUSY}, 32'd0);
        check("s10_grant_id", {29'd0, GRANT_ID}, 32'd2);

        // Three sources of 8 words, burst limit 3.
        do_reset();
        load(0, 8); load(1, 8); load(4, 8);
        BURST_MAX = 8'd3;
        for (int i = 0; i < W; i++) kk[i] = 0;
        for (int b = 0; b < 9; b++) begin
            for (int k = 0; k < ((b < 6) ? 3 : 2); k++) begin
                exp_q.push_back(mk((b % 3 == 2) ? 4 : (b % 3), kk[(b % 3 == 2) ? 4 : (b % 3)]));
                kk[(b % 3 == 2) ? 4 : (b % 3)]++;
            end
        end
        started = 1'b0; idle = 0; n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            tick();
            n++;
            if (OUT_WRITE) started = 1'b1;
            if (started && exp_q.size() > 0 && !BUSY) idle++;
        end
        check("rr3_drain", exp_q.size(), 32'd0);
        check("rr3_idle_cycles", idle, 32'd8);
        tick();

        // Sink backpressure toggling every cycle through a 6-word burst.
        do_reset();
        load(3, 6);
        model_rr(0, 0);
        w0 = nwr; n = 0;
`ifdef BURST_RR_ARBITER_STATS_EN
        stall_exp = 0;
`endif
        while (exp_q.size() > 0 && n < 60) begin
`ifdef BURST_RR_ARBITER_STATS_EN
            if (BUSY && !OUT_READY && !SRC_EMPTY[3]) stall_exp++;
`endif
            tick();
            OUT_READY = ~OUT_READY;
            n++;
        end
        OUT_READY = 1'b1;
        tick();
        tick();
        check("bp_drain", exp_q.size(), 32'd0);
        check("bp_count", nwr - w0, 32'd6);
        check("bp_busy_end", {31'd0, BUSY}, 32'd0);
`ifdef BURST_RR_ARBITER_STATS_EN
        check("bp_stall_cnt", {16'd0, STALL_CNT}, stall_exp);
`endif

        // Source 1 disabled after its 2nd pop; next grant must be source 3, not 0.
        do_reset();
        load(1, 6); load(3, 2);
        exp_q.push_back(mk(1, 0)); exp_q.push_back(mk(1, 1));
        exp_q.push_back(mk(3, 0)); exp_q.push_back(mk(3, 1));
        exp_q.push_back(mk(0, 0)); exp_q.push_back(mk(0, 1));
        dis = 1'b0; ld0 = 1'b0; n = 0;
        while (exp_q.size() > 0 && n < 80) begin
            tick();
            n++;
            if (!ld0 && OUT_WRITE) begin
                load(0, 2);
                ld0 = 1'b1;
            end
            if (!dis && pops[1] == 2) begin
                SRC_ENABLE[1] = 1'b0;
                dis = 1'b1;
            end
        end
        check("dis_drain", exp_q.size(), 32'd0);
        tick();
        check("dis_pops_src1", pops[1], 32'd2);
        check("dis_left_src1", fifo[1].size(), 32'd4);

        // BURST_MAX lowered below the running count mid-burst.
        do_reset();
        load(2, 8);
        for (int k = 0; k < 3; k++) exp_q.push_back(mk(2, k));
        w0 = nwr; n = 0;
        while (nwr - w0 < 3 && n < 30) begin
            tick();
            n++;
        end
        check("bm_low_reach", nwr - w0, 32'd3);
        BURST_MAX = 8'd2;
        tick();
        check("bm_low_stop_write", {31'd0, OUT_WRITE}, 32'd0);
        check("bm_low_exit", {31'd0, BUSY}, 32'd0);
        model_rr(3, 2);
        drain("bm_low_drain", 60);

        // Reset in the middle of a source-3 burst.
        do_reset();
        load(3, 8);
        model_rr(0, 0);
        w0 = nwr; n = 0;
        while (nwr - w0 < 3 && n < 30) begin
            tick();
            n++;
        end
        check("rst_mid_reach", nwr - w0, 32'd3);
        RST = 1'b1;
        #1;
        check("rst_mid_out_write", {31'd0, OUT_WRITE}, 32'd0);
        check("rst_mid_src_read", {27'd0, SRC_READ}, 32'd0);
        check("rst_mid_busy", {31'd0, BUSY}, 32'd0);
        check("rst_mid_grant_id", {29'd0, GRANT_ID}, 32'd0);
        exp_q.delete();
        tick();
        load(1, 2);
        check("rst_mid_left_src3", fifo[3].size(), 32'd5);
        RST = 1'b0;
        model_rr(0, 0);
        tick();
        check("rst_rel_busy", {31'd0, BUSY}, 32'd1);
        check("rst_rel_grant_id", {29'd0, GRANT_ID}, 32'd1);
        drain("rst_rel_drain", 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
